regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ writeback requesters (e.g. 0 = ALU, 1 = load unit, 2 = mult/div).
- Uses a per-requester valid/ready handshake and round-robin arbitration.
- Drives WrEn/WrReg/WrData from a registered output stage, so the register file sees one clean write per cycle.
- Sits between the execute/memory writeback sources and the register file.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8)
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- ID_W, 2, grant id width; must be at least clog2(NUM_REQ)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- hold  input  1  freezes arbitration; no requester is accepted while high
- req_valid  input  NUM_REQ  per-requester write request valid
- req_ready  output  NUM_REQ  per-requester accept; combinational; one-hot or zero
- req_reg  input  NUM_REQ*ADDR_W  packed destination register; requester i at [i*ADDR_W +: ADDR_W]
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
- WrEn  output  1  register-file write enable (registered)
- WrReg  output  ADDR_W  register-file write index (registered)
- WrData  output  DATA_W  register-file write data (registered)
- grant_id  output  ID_W  index of the requester whose write is on WrEn this cycle (registered)
- busy  output  1  high when any req_valid is high and that requester is not accepted this cycle (combinational)

Behaviour:
- Reset (async, rst=1):
  - WrEn=0, WrReg=0, WrData=0, grant_id=0.
  - Round-robin pointer = 0, so requester 0 has top priority on the first post-reset cycle.
  - A write accepted in the cycle before reset is discarded (WrEn forced 0 immediately).
  - req_ready=0 while rst=1.
- Arbitration (combinational, each cycle with hold=0, rst=0):
  - Scan from the pointer upward, modulo NUM_REQ; the first requester with req_valid=1 wins.
  - The winner gets req_ready[i]=1; all others get 0.
  - No valid requester: req_ready=0.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i].
  - A requester must hold req_valid, req_reg and req_data stable until accepted.
  - The arbiter never withdraws ready within a cycle.
- Output stage, on each rising edge:
  - If a transfer occurred: WrReg <= req_reg[i], WrData <= req_data[i], grant_id <= i, and WrEn <= 1 unless req_reg[i]==0.
  - Otherwise WrEn <= 0, and WrReg, WrData and grant_id hold their values.
  - Latency: accept in cycle N, write presented in cycle N+1 and committed by the register file at the end of N+1.
- Register 0: the request is accepted (handshake completes) but WrEn stays 0. Write is silently dropped; grant_id still updates.
- Pointer update: after a transfer from requester i, pointer <= (i+1) mod NUM_REQ. With no transfer, the pointer holds.
- Fairness: with hold=0, a continuously valid requester is accepted within NUM_REQ cycles.
- Throughput: one write per cycle when requests are available; no bubbles between back-to-back grants.
- hold=1:
  - All req_ready=0; pointer holds; next-edge WrEn=0.
  - A write already in the output stage still completes this cycle.
- Same destination from two requesters: serialized in grant order. The later grant's data is the final register value. No merging and no error flag.
- busy=1 when (|req_valid) and no transfer occurs, or when more than one req_valid is high.

Optional Feature:
- Macro: WB_FIXED_PRIORITY_EN.
- Defined: the pointer is removed; requester 0 always has highest priority, then 1, 2, ... Starvation of higher indices is permitted. All other behaviour is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset check: rst=1 asynchronously mid-cycle while WrEn=1 -> WrEn, WrReg, WrData and grant_id drop to 0 without waiting for a clock edge. On the first cycle after release, req_valid=3'b111 -> req_ready=3'b001.
- Single write: req_valid=3'b010, req_reg[1]=5'd9, req_data[1]=32'hDEADBEEF -> req_ready=3'b010 that cycle. Next cycle WrEn=1, WrReg=9, WrData=32'hDEADBEEF, grant_id=1.
- Round robin: req_valid=3'b111 held for 6 cycles, pointer=0 -> grants 0,1,2,0,1,2. WrEn=1 every cycle from the 2nd; grant_id sequence lags the grants by one cycle.
- Register-0 drop: req_valid=3'b001, req_reg[0]=0, req_data[0]=32'h1234 -> req_ready[0]=1. Next cycle WrEn=0, grant_id=0, and the pointer advances to 1.
- Hold: req_valid=3'b101 with hold=1 for 3 cycles -> req_ready=0 and WrEn=0 throughout. hold falls -> requester 0 granted first, requester 2 granted the next cycle.
- With WB_FIXED_PRIORITY_EN defined: req_valid=3'b011 held for 4 cycles -> requester 0 granted every cycle and req_ready[1] stays 0. busy=1 throughout.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback sources.
// Define WB_FIXED_PRIORITY_EN to replace round-robin with fixed priority (requester 0 highest).
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      WrEn,
  output logic [ADDR_W-1:0]         WrReg,
  output logic [DATA_W-1:0]         WrData,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] rot_valid;
  logic [NUM_REQ-1:0] rot_gnt;
  logic [NUM_REQ-1:0] gnt;
  logic               xfer;
  logic [ID_W-1:0]    win_id;
  logic [ADDR_W-1:0]  sel_reg;
  logic [DATA_W-1:0]  sel_data;

`ifndef WB_FIXED_PRIORITY_EN
  logic [ID_W-1:0]      ptr;
  logic [2*NUM_REQ-1:0] gnt_dbl;
`endif

  // Rotate requests so the pointer lands on bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    elig = (rst || hold) ? '0 : req_valid;
`ifdef WB_FIXED_PRIORITY_EN
    rot_valid = elig;
`else
    rot_valid = NUM_REQ'({elig, elig} >> ptr);
`endif
    rot_gnt = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) rot_gnt = NUM_REQ'(1) << k;
    end
`ifdef WB_FIXED_PRIORITY_EN
    gnt = rot_gnt;
`else
    gnt_dbl = {NUM_REQ'(0), rot_gnt} << ptr;
    gnt     = gnt_dbl[NUM_REQ-1:0] | gnt_dbl[2*NUM_REQ-1:NUM_REQ];
`endif
  end

  // Select the winning requester's payload.
  always_comb begin
    xfer     = |gnt;
    win_id   = '0;
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_id   = ID_W'(i);
        sel_reg  = req_reg[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = gnt;
  assign busy      = (|req_valid & ~xfer) | (|(req_valid & (req_valid - NUM_REQ'(1))));

  // Output stage; writes to register 0 complete the handshake but never assert WrEn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WrEn     <= 1'b0;
      WrReg    <= '0;
      WrData   <= '0;
      grant_id <= '0;
    end else begin
      WrEn <= xfer && (sel_reg != '0);
      if (xfer) begin
        WrReg    <= sel_reg;
        WrData   <= sel_data;
        grant_id <= win_id;
      end
    end
  end

`ifndef WB_FIXED_PRIORITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reference arbiter model plus a one-deep write scoreboard.
module tb_regfile_wb_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] r;
    logic [DW-1:0] d;
    logic [IW-1:0] id;
  } wr_t;

  logic            clk;
  logic            rst;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_reg;
  logic [N*DW-1:0] req_data;
  logic            WrEn;
  logic [AW-1:0]   WrReg;
  logic [DW-1:0]   WrData;
  logic [IW-1:0]   grant_id;
  logic            busy;

  logic [AW-1:0] rreg  [N];
  logic [DW-1:0] rdata [N];

  wr_t sb[$];
  wr_t last;
  int  total = 0;
  int  bad   = 0;
  int  mptr  = 0;

  assign req_reg  = {rreg[2], rreg[1], rreg[0]};
  assign req_data = {rdata[2], rdata[1], rdata[0]};

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data),
    .WrEn(WrEn), .WrReg(WrReg), .WrData(WrData),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbiter: linear scan from the pointer, modulo N.
  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input int p);
    logic [N-1:0] g;
    logic [1:0]   idx;
    g = '0;
    for (int k = 0; k < N; k++) begin
      idx = 2'((p + k) % N);
      if (g == '0 && v[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

  task automatic cycle(input logic [N-1:0] v, input logic h);
    logic [N-1:0] er;
    logic         eb;
    int           id;
    wr_t          e;
    req_valid = v;
    hold      = h;
    #1;
`ifdef WB_FIXED_PRIORITY_EN
    er = h ? '0 : model_grant(v, 0);
`else
    er = h ? '0 : model_grant(v, mptr);
`endif
    eb = (v != '0 && er == '0) || ((v & (v - 3'd1)) != '0);
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("busy", 64'(busy), 64'(eb));
    if (er != '0) begin
      id = 0;
      for (int i = 0; i < N; i++) if (er[i]) id = i;
      e.en = (rreg[id] != '0);
      e.r  = rreg[id];
      e.d  = rdata[id];
      e.id = IW'(id);
      last = e;
      mptr = (id + 1) % N;
    end else begin
      e    = last;
      e.en = 1'b0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      chk("WrEn", 64'(WrEn), 64'(e.en));
      chk("WrReg", 64'(WrReg), 64'(e.r));
      chk("WrData", 64'(WrData), 64'(e.d));
      chk("grant_id", 64'(grant_id), 64'(e.id));
    end
  endtask

  initial begin
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    last      = '0;
    for (int i = 0; i < N; i++) begin
      rreg[i]  = '0;
      rdata[i] = '0;
    end
    #12;
    chk("rst_WrEn", 64'(WrEn), 64'(0));
    chk("rst_WrReg", 64'(WrReg), 64'(0));
    chk("rst_WrData", 64'(WrData), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    #1 rst = 1'b0;

    // Single write from requester 1.
    rreg[1] = 5'd9; rdata[1] = 32'hDEADBEEF;
    cycle(3'b010, 1'b0);
    chk("single_WrReg", 64'(WrReg), 64'd9);
    chk("single_WrData", 64'(WrData), 64'hDEADBEEF);

    // Asynchronous reset while a write is on the port.
    rreg[0] = 5'd3; rdata[0] = 32'h0000AAAA;
    cycle(3'b001, 1'b0);
    chk("pre_rst_WrEn", 64'(WrEn), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_WrEn", 64'(WrEn), 64'(0));
    chk("async_WrReg", 64'(WrReg), 64'(0));
    chk("async_WrData", 64'(WrData), 64'(0));
    chk("async_grant_id", 64'(grant_id), 64'(0));
    chk("async_ready", 64'(req_ready), 64'(0));
    sb.delete();
    last = '0;
    mptr = 0;
    #1 rst = 1'b0;

    // Round robin with all requesters valid: grants 0,1,2,0,1,2.
    rreg[0] = 5'd1; rdata[0] = 32'h11110000;
    rreg[1] = 5'd2; rdata[1] = 32'h22220000;
    rreg[2] = 5'd3; rdata[2] = 32'h33330000;
    for (int c = 0; c < 6; c++) cycle(3'b111, 1'b0);

    // Register-0 write: accepted but WrEn stays low; pointer still advances.
    rreg[0] = 5'd0; rdata[0] = 32'h00001234;
    cycle(3'b001, 1'b0);
    cycle(3'b011, 1'b0);
    cycle(3'b100, 1'b0);

    // Hold freezes arbitration for three cycles.
    rreg[0] = 5'd4; rdata[0] = 32'h44440000;
    rreg[2] = 5'd6; rdata[2] = 32'h66660000;
    for (int c = 0; c < 3; c++) cycle(3'b101, 1'b1);
    cycle(3'b101, 1'b0);
    cycle(3'b100, 1'b0);
    cycle(3'b000, 1'b0);

    // Two requesters targeting the same register are serialized.
    rreg[0] = 5'd7; rdata[0] = 32'hA0A0A0A0;
    rreg[1] = 5'd7; rdata[1] = 32'hB1B1B1B1;
    cycle(3'b011, 1'b0);
    cycle(3'b010, 1'b0);
    cycle(3'b000, 1'b0);

    // Two continuously valid requesters for four cycles.
    for (int c = 0; c < 4; c++) cycle(3'b011, 1'b0);
`ifdef WB_FIXED_PRIORITY_EN
    chk("fixed_grant_id", 64'(grant_id), 64'(0));
`endif
    cycle(3'b000, 1'b0);

    // Random traffic against the reference model.
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++) begin
        rreg[i]  = 5'($urandom_range(0, 31));
        rdata[i] = $urandom;
      end
      cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
